// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared L1 data-cache definitions: tag-entry field positions,
//               geometry constants and the flush sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Tag entry layout: {valid, dirty, tag[21:0]}
  localparam int VALID_BIT   = 23;
  localparam int DIRTY_BIT   = 22;
  localparam int TAG_MSB     = 21;
  localparam int TAG_ENTRY_W = 24;

  // Cache geometry
  localparam int LINE_W   = 256;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 5;

  // Flush sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WRITE  = 3'd2,
    CLEAN  = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } flush_state_e;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/dcache_flush_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_flush_ctrl_if
// Description : Memory write port between the flush sequencer (master) and
//               Data_Memory (slave): enable/write request with a one-cycle
//               acknowledge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_flush_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);

  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic              mem_ack_i;

  // Requester side: drives the request, receives the acknowledge
  modport master (
    output mem_addr_o,
    output mem_data_o,
    output mem_enable_o,
    output mem_write_o,
    input  mem_ack_i
  );

  // Memory side: observes the request, returns the acknowledge
  modport slave (
    input  mem_addr_o,
    input  mem_data_o,
    input  mem_enable_o,
    input  mem_write_o,
    output mem_ack_i
  );

endinterface : dcache_flush_ctrl_if
`default_nettype wire

// File: rtl/dcache_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_flush_ctrl
// Description : Write-back flush sequencer for the direct-mapped L1 data
//               cache. Walks every index, writes each valid+dirty line to
//               memory, then clears its dirty bit (and optionally valid).
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_flush_ctrl #(
  parameter int NUM_LINES  = 32,
  parameter int INDEX_W    = 5,
  parameter int TAG_W      = 22,
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int INVALIDATE = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_req_i,
  input  logic                 cache_mem_busy_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [INDEX_W:0]     lines_written_o,
  output logic [INDEX_W-1:0]   sram_idx_o,
  input  logic [TAG_W+1:0]     tag_rd_i,
  input  logic [LINE_W-1:0]    data_rd_i,
  output logic                 tag_we_o,
  output logic [TAG_W+1:0]     tag_wd_o,
  dcache_flush_ctrl_if.master  mem_if
);

  import cache_pkg::*;

  localparam logic [INDEX_W-1:0] LAST_IDX   = INDEX_W'(NUM_LINES - 1);
  localparam logic               KEEP_VALID = (INVALIDATE == 0);

  flush_state_e         state_q;
  logic [INDEX_W-1:0]   index_q;
  logic [INDEX_W:0]     lines_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tag_we_q;
  logic [TAG_W+1:0]     tag_wd_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 mem_en_q;
  logic                 mem_wr_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [LINE_W-1:0]    mem_data_q;

  // Next-value terms consumed by the sequencer
  logic                 dirty_hit_d;
  logic [INDEX_W-1:0]   index_d;
  logic [INDEX_W:0]     lines_d;
  logic [ADDR_W-1:0]    mem_addr_d;
  logic [TAG_W+1:0]     tag_wd_d;

  // A line needs write-back only when it is both valid and dirty
  assign dirty_hit_d = tag_rd_i[VALID_BIT] & tag_rd_i[DIRTY_BIT];
  assign index_d     = index_q + 1'b1;
  assign lines_d     = lines_q + 1'b1;
  // Line base address rebuilt from the stored tag and the walk index
  assign mem_addr_d  = {tag_rd_i[TAG_MSB:0], index_q, {OFFSET_W{1'b0}}};
  // Written-back entry: dirty cleared, valid kept unless invalidating
  assign tag_wd_d    = {KEEP_VALID, 1'b0, tag_q};

  // Flush sequencer: walks all indices, all outputs registered
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      index_q    <= '0;
      lines_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tag_we_q   <= 1'b0;
      tag_wd_q   <= '0;
      tag_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      // Single-cycle strobes default low
      done_q   <= 1'b0;
      tag_we_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // A request is only accepted once the cache controller has no
          // memory transaction in flight; a dropped request is not kept.
          if (flush_req_i && !cache_mem_busy_i) begin
            index_q <= '0;
            lines_q <= '0;
            busy_q  <= 1'b1;
            state_q <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (dirty_hit_d) begin
            tag_q      <= tag_rd_i[TAG_MSB:0];
            mem_addr_q <= mem_addr_d;
            mem_data_q <= data_rd_i;
            mem_en_q   <= 1'b1;
            mem_wr_q   <= 1'b1;
            state_q    <= WRITE;
          end else begin
            state_q <= NEXT;
          end
        end

        WRITE: begin
          // Address and data are held until memory acknowledges
          if (mem_if.mem_ack_i) begin
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            lines_q  <= lines_d;
            tag_we_q <= 1'b1;
            tag_wd_q <= tag_wd_d;
            state_q  <= CLEAN;
          end
        end

        CLEAN: begin
          // tag_we_o is high for exactly this cycle
          state_q <= NEXT;
        end

        NEXT: begin
          if (index_q == LAST_IDX) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            index_q <= index_d;
            state_q <= LOOKUP;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q   <= 1'b0;
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign lines_written_o     = lines_q;
  assign sram_idx_o          = index_q;
  assign tag_we_o            = tag_we_q;
  assign tag_wd_o            = tag_wd_q;
  assign mem_if.mem_addr_o   = mem_addr_q;
  assign mem_if.mem_data_o   = mem_data_q;
  assign mem_if.mem_enable_o = mem_en_q;
  assign mem_if.mem_write_o  = mem_wr_q;

endmodule : dcache_flush_ctrl
`default_nettype wire
